// File: rtl/scs8hd_and4b_seq_pkg.sv
// Shared types and constants for the and4b operand sequencer.
package scs8hd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Pin value that forces the and4b cell output low while nothing is driven.
    localparam logic [3:0] SAFE_PINS = 4'b1000;

    // Bit positions of the cell pins inside an operand vector.
    localparam int AN_I = 3;
    localparam int B_I  = 2;
    localparam int C_I  = 1;
    localparam int D_I  = 0;

    // Reference and4b function: X = ~AN & B & C & D.
    function automatic logic and4b_ref(input logic [3:0] v);
        return ~v[AN_I] & v[B_I] & v[C_I] & v[D_I];
    endfunction

endpackage

// File: rtl/scs8hd_and4b_seq_if.sv
// Operand-in / result-out stream handshakes of the sequencer.
interface scs8hd_and4b_seq_if;

    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_vec;
    logic       out_x;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_x
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_x
    );

endinterface

// File: rtl/scs8hd_and4b_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push is ignored when full,
// pop is ignored when empty.
module scs8hd_fifo_sync #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("scs8hd_fifo_sync: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; the wrap bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; emptying is done by the
    // pointers, and leaving memory unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/scs8hd_and4b_seq.sv
// Operand sequencer for an and4b cell: buffers vectors, holds each on the
// cell pins for HOLD cycles, samples X, and reports {vector, X} downstream
// with a sticky flag for any X that disagrees with ~AN&B&C&D.
module scs8hd_and4b_seq
    import scs8hd_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                 CLK,
    input  logic                 RESETB,
    scs8hd_and4b_seq_if.slave    bus,
    output logic                 AN,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    input  logic                 X,
    output logic                 busy,
    output logic                 err
);

    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("scs8hd_and4b_seq: HOLD must be in 1..15");
    end

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_e     state;
    logic [3:0] cnt;
    logic [3:0] pins;
    logic       out_valid_q;
    logic [3:0] out_vec_q;
    logic       out_x_q;
    logic       err_q;

    logic [3:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       capture;
    logic       exp_x;

    // A pop needs the result slot free now or being freed at this edge,
    // so a capture never overwrites an unconsumed result.
    assign pop     = (state == IDLE) && !fifo_empty && (!out_valid_q || bus.out_ready);
    assign capture = (state == DRIVE) && (cnt == 4'd0);
    assign exp_x   = and4b_ref(pins);

    scs8hd_fifo_sync #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETB),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata (bus.in_vec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer FSM with registered pins, result register and sticky error.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state       <= IDLE;
            cnt         <= '0;
            pins        <= SAFE_PINS;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_x_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        pins  <= head;
                        cnt   <= HOLD_M1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        pins  <= SAFE_PINS;
                        state <= IDLE;
                    end
                end
                default: begin
                    pins  <= SAFE_PINS;
                    state <= IDLE;
                end
            endcase

            if (capture) begin
                out_vec_q   <= pins;
                out_x_q     <= X;
                out_valid_q <= 1'b1;
                // Case inequality so an unknown X from the cell also flags.
                if (X !== exp_x) err_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign AN = pins[AN_I];
    assign B  = pins[B_I];
    assign C  = pins[C_I];
    assign D  = pins[D_I];

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_x     = out_x_q;

    assign busy = (state != IDLE) || !fifo_empty;
    assign err  = err_q;

endmodule
